rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, ROM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, ROM data width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  NUM_PORTS  per-port read request.
REQ-007 SHALL have port req_addr  input  NUM_PORTS*ADDR_WIDTH  flattened per-port addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_PORTS  one-hot grant, request accepted when valid and ready are both high.
REQ-009 SHALL have port rsp_valid  output  NUM_PORTS  one-hot read-data strobe.
REQ-010 SHALL have port rsp_data  output  DATA_WIDTH  shared read data, meaningful only when rsp_valid is non-zero.
REQ-011 SHALL have port fixed_prio  input  1  1 = fixed priority (lowest index wins), 0 = round-robin.
REQ-012 SHALL have port rom_addr  output  ADDR_WIDTH  address to single-port ROM, which registers it internally.
REQ-013 SHALL have port rom_data  input  DATA_WIDTH  ROM read data, valid the cycle after rom_addr is sampled.

Function
REQ-014 SHALL grant at most one port per cycle; req_ready is combinational from req_valid, fixed_prio and the priority pointer.
REQ-015 SHALL drive req_ready[i] only when req_valid[i] is high; req_ready SHALL be zero when req_valid is zero.
REQ-016 SHALL, in round-robin mode, give highest priority to the port after last_grant (wrapping NUM_PORTS-1 -> 0) and search upward with wrap.
REQ-017 SHALL update last_grant to the granted index on every cycle with a grant, and hold it otherwise, in both modes.
REQ-018 SHALL, in fixed-priority mode, grant the lowest-index valid port regardless of last_grant.
REQ-019 SHALL drive rom_addr combinationally from req_addr of the granted port; it SHALL be all-zero on cycles with no grant.
REQ-020 SHALL register the grant vector into rsp_owner; rsp_valid = rsp_owner, giving fixed latency of 1 cycle from accept to response.
REQ-021 SHALL pass rom_data to rsp_data combinationally, unregistered.
REQ-022 SHALL sustain one accept per cycle, back-to-back, with no bubbles, including consecutive grants to the same port.
REQ-023 SHALL provide no response backpressure; each rsp_valid pulse lasts exactly 1 cycle and requesters must sample it.
REQ-024 SHALL allow fixed_prio to change on any cycle; it takes effect on the same cycle's arbitration.
REQ-025 SHALL ignore req_addr of non-granted ports, and SHALL ignore X on them.

Reset
REQ-026 SHALL, while rst_n is low, force rsp_owner = 0 and last_grant = NUM_PORTS-1, so port 0 has first round-robin priority.
REQ-027 SHALL, while rst_n is low, force req_ready = 0, so no accept occurs during reset.
REQ-028 SHALL drop any response in flight when reset is asserted mid-operation; no rsp_valid SHALL follow after reset deasserts.
REQ-029 SHALL allow arbitration on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL cover single port: port 2 valid, addr=0x05, for 1 cycle -> req_ready=0b0100 same cycle, rom_addr=0x05, next cycle rsp_valid=0b0100 and rsp_data=0x05 with ROM mem[i]=i.
REQ-031 SHALL cover round-robin: all 4 ports valid continuously with fixed_prio=0 after reset -> grants 0,1,2,3,0,...; each rsp_valid follows its grant by 1 cycle with matching data.
REQ-032 SHALL cover fixed priority: ports 1 and 3 valid continuously with fixed_prio=1 -> port 1 granted every cycle and port 3 starved; switching to fixed_prio=0 grants port 3 on the next cycle.
REQ-033 SHALL cover pointer wrap: last grant = port 3, then ports 0 and 3 valid -> port 0 granted.
REQ-034 SHALL cover reset mid-flight: accept on port 1, assert rst_n low before the next edge -> rsp_valid stays 0; after release, port 0 wins ties.
REQ-035 SHALL cover the idle cycle: req_valid=0 -> req_ready=0, rom_addr=0x00, rsp_valid=0 next cycle, last_grant unchanged.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: N-port read arbiter in front of a single-port synchronous ROM.
// One grant per cycle, round-robin or fixed priority. Each response is returned
// one cycle after its accept on a shared data bus, with a one-hot owner strobe.
module rom_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  input  logic                             fixed_prio,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  input  logic [DATA_WIDTH-1:0]            rom_data
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0]     last_grant;
  logic [NUM_PORTS-1:0] rsp_owner;
  logic [NUM_PORTS-1:0] upper_mask;
  logic [NUM_PORTS-1:0] upper_req;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;

  // Isolate the lowest set bit of a request vector (one-hot result).
  function automatic logic [NUM_PORTS-1:0] lowest_one(input logic [NUM_PORTS-1:0] v);
    return v & (~v + NUM_PORTS'(1));
  endfunction

  // Ports strictly above the last grant have first round-robin priority.
  always_comb begin
    upper_mask = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      upper_mask[i] = (IDX_W'(i) > last_grant);
    end
  end

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    upper_req = req_valid & upper_mask;
    grant     = '0;
    if (!rst_n) begin
      grant = '0;
    end else if (fixed_prio) begin
      grant = lowest_one(req_valid);
    end else if (|upper_req) begin
      grant = lowest_one(upper_req);
    end else begin
      grant = lowest_one(req_valid);
    end
  end

  // Encode the one-hot grant and steer the granted port's address to the ROM.
  always_comb begin
    grant_idx = '0;
    rom_addr  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        rom_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign grant_any = |grant;
  assign req_ready = grant;
  assign rsp_valid = rsp_owner;
  assign rsp_data  = rom_data;

  // Track response ownership and the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner  <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
    end else begin
      rsp_owner <= grant;
      if (grant_any) begin
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: randomized and directed checks of rom_arbiter against a
// behavioural model (pointer integer + expected response owner/data).
module tb_rom_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            fixed_prio;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;

  always #5 clk = ~clk;

  rom_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .fixed_prio(fixed_prio), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  // ROM model: registered address, mem[i] = i.
  logic [AW-1:0] rom_q;
  always @(posedge clk) rom_q <= rom_addr;
  assign rom_data = DW'(rom_q);

  // Behavioural model state.
  int            m_lg;
  logic [N-1:0]  m_owner;
  logic [DW-1:0] m_data;

  // Snapshots of DUT outputs from the latest step, for literal expectations.
  logic [N-1:0]  s_ready;
  logic [AW-1:0] s_rom;
  logic [N-1:0]  s_rsp;
  logic [DW-1:0] s_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic fp,
                      input logic rst_in, input logic late_rst);
    logic [N-1:0]  g;
    logic [AW-1:0] ea;
    int            gi;
    int            p;
    req_valid  = v;
    req_addr   = a;
    fixed_prio = fp;
    rst_n      = rst_in;
    if (!rst_in) begin
      m_owner = '0;
      m_lg    = N - 1;
    end
    @(negedge clk);
    g  = '0;
    ea = '0;
    gi = -1;
    if (rst_in) begin
      if (fp) begin
        for (int i = 0; i < N; i++) if (v[i] && gi < 0) gi = i;
      end else begin
        for (int k = 1; k <= N; k++) begin
          p = (m_lg + k) % N;
          if (v[p] && gi < 0) gi = p;
        end
      end
    end
    if (gi >= 0) begin
      g[gi] = 1'b1;
      ea    = a[gi*AW +: AW];
    end
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("rom_addr",  32'(rom_addr),  32'(ea));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_owner));
    if (m_owner != '0) chk("rsp_data", 32'(rsp_data), 32'(m_data));
    s_ready = req_ready;
    s_rom   = rom_addr;
    s_rsp   = rsp_valid;
    s_data  = rsp_data;
    if (late_rst) begin
      rst_n = 1'b0;
      g     = '0;
      gi    = -1;
      m_lg  = N - 1;
    end
    @(posedge clk);
    #1;
    m_owner = g;
    m_data  = DW'(ea);
    if (gi >= 0) m_lg = gi;
  endtask

  function automatic logic [N*AW-1:0] std_addr();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(8'h10 * i + 8'h01);
    return a;
  endfunction

  logic [N*AW-1:0] a0;

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    fixed_prio = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    step('0, '0, 1'b0, 1'b0, 1'b0);
    step(4'b1111, std_addr(), 1'b0, 1'b0, 1'b0);
    chk("reset_ready", 32'(s_ready), 32'h0);
    chk("reset_rsp",   32'(s_rsp),   32'h0);

    // Single port: port 2, address 0x05.
    a0 = '0;
    a0[2*AW +: AW] = 8'h05;
    step(4'b0100, a0, 1'b0, 1'b1, 1'b0);
    chk("single_ready", 32'(s_ready), 32'h4);
    chk("single_addr",  32'(s_rom),   32'h05);
    step('0, '0, 1'b0, 1'b1, 1'b0);
    chk("single_rsp",   32'(s_rsp),   32'h4);
    chk("single_data",  32'(s_data),  32'h05);
    chk("idle_addr",    32'(s_rom),   32'h00);

    // Round-robin after reset: 0,1,2,3,0.
    step('0, '0, 1'b0, 1'b0, 1'b0);
    step(4'b1111, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("rr_g0", 32'(s_ready), 32'h1);
    step(4'b1111, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("rr_g1", 32'(s_ready), 32'h2);
    chk("rr_r0", 32'(s_rsp),   32'h1);
    chk("rr_d0", 32'(s_data),  32'h01);
    step(4'b1111, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("rr_g2", 32'(s_ready), 32'h4);
    step(4'b1111, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("rr_g3", 32'(s_ready), 32'h8);
    chk("rr_d2", 32'(s_data),  32'h21);
    step(4'b1111, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("rr_g4", 32'(s_ready), 32'h1);
    chk("rr_r3", 32'(s_rsp),   32'h8);

    // Fixed priority: port 1 starves port 3, then round-robin gives port 3.
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, std_addr(), 1'b1, 1'b1, 1'b0);
      chk("fp_g1", 32'(s_ready), 32'h2);
    end
    step(4'b1010, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("fp_switch", 32'(s_ready), 32'h8);

    // Pointer wrap: last grant 3, ports 0 and 3 valid.
    step(4'b1001, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("wrap", 32'(s_ready), 32'h1);

    // Idle cycle leaves pointer at 0, so port 1 wins next.
    step('0, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("idle_ready", 32'(s_ready), 32'h0);
    chk("idle_rom",   32'(s_rom),   32'h0);
    step(4'b1111, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("idle_rsp",   32'(s_rsp),   32'h0);
    chk("idle_hold",  32'(s_ready), 32'h2);

    // Reset mid-flight: accept on port 1 then reset before the edge.
    step(4'b0010, std_addr(), 1'b0, 1'b1, 1'b1);
    chk("mid_accept", 32'(s_ready), 32'h2);
    step('0, '0, 1'b0, 1'b0, 1'b0);
    chk("mid_rsp_rst", 32'(s_rsp), 32'h0);
    step(4'b1111, std_addr(), 1'b0, 1'b1, 1'b0);
    chk("mid_rsp_after", 32'(s_rsp),   32'h0);
    chk("mid_tie",       32'(s_ready), 32'h1);

    // Randomized traffic with X on unused addresses, mode flips and resets.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0]    v;
      logic [N*AW-1:0] a;
      logic            fp;
      int              r;
      v  = N'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & N'($urandom);
      fp = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (v[i] || $urandom_range(0, 1) == 1) a[i*AW +: AW] = AW'($urandom);
        else a[i*AW +: AW] = 'x;
      end
      r = $urandom_range(0, 99);
      step(v, a, fp, r != 0, r == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
